// File: rtl/n2_mult_pkg.sv
// Shared widths and constants for the approximate recursive 4x4 multiplier.
package n2_mult_pkg;
    localparam int OPER_W = 4;
    localparam int HALF_W = 2;
    localparam int PROD_W = 8;
    localparam int CELL_W = 2 * HALF_W;
    localparam logic [CELL_W-1:0] APPROX_3X3 = 4'd7;
endpackage

// File: rtl/n2_mult4x4_approx_if.sv
// Operand/result bundle between a datapath master and the multiplier.
interface n2_mult4x4_approx_if;
    import n2_mult_pkg::*;
    logic              in_valid;
    logic [OPER_W-1:0] a;
    logic [OPER_W-1:0] b;
    logic [PROD_W-1:0] y;
    logic              out_valid;

    modport master (output in_valid, a, b, input y, out_valid);
    modport slave  (input in_valid, a, b, output y, out_valid);
endinterface

// File: rtl/n2_mult2x2_approx.sv
// Combinational 2x2 cell; with APPROX set, 3x3 yields 7 so the MSB is never needed.
module n2_mult2x2_approx
    import n2_mult_pkg::*;
#(
    parameter int APPROX = 1
) (
    input  logic [HALF_W-1:0] x_i,
    input  logic [HALF_W-1:0] y_i,
    output logic [CELL_W-1:0] p_o
);
    logic [CELL_W-1:0] exact_d;

    assign exact_d = CELL_W'(x_i) * CELL_W'(y_i);
    assign p_o     = ((APPROX != 0) && (&x_i) && (&y_i)) ? APPROX_3X3 : exact_d;
endmodule

// File: rtl/n2_mult4x4_approx.sv
// Registered 4x4 multiplier built from four 2x2 cells summed exactly; 1-cycle latency.
module n2_mult4x4_approx
    import n2_mult_pkg::*;
#(
    parameter int APPROX = 1
) (
    input  logic                clk,
    input  logic                rst,
    n2_mult4x4_approx_if.slave  bus
);
    logic [CELL_W-1:0] m_ll, m_hl, m_lh, m_hh;
    logic [PROD_W-1:0] sum_d;
    logic [PROD_W-1:0] y_d, y_q;
    logic              out_valid_d, out_valid_q;

    n2_mult2x2_approx #(.APPROX(APPROX)) u_ll (
        .x_i(bus.a[HALF_W-1:0]), .y_i(bus.b[HALF_W-1:0]), .p_o(m_ll));
    n2_mult2x2_approx #(.APPROX(APPROX)) u_hl (
        .x_i(bus.a[OPER_W-1:HALF_W]), .y_i(bus.b[HALF_W-1:0]), .p_o(m_hl));
    n2_mult2x2_approx #(.APPROX(APPROX)) u_lh (
        .x_i(bus.a[HALF_W-1:0]), .y_i(bus.b[OPER_W-1:HALF_W]), .p_o(m_lh));
    n2_mult2x2_approx #(.APPROX(APPROX)) u_hh (
        .x_i(bus.a[OPER_W-1:HALF_W]), .y_i(bus.b[OPER_W-1:HALF_W]), .p_o(m_hh));

    // Worst case 7+28+28+112 = 175 fits in PROD_W without overflow.
    assign sum_d = PROD_W'(m_ll)
                 + (PROD_W'(m_hl) << HALF_W)
                 + (PROD_W'(m_lh) << HALF_W)
                 + (PROD_W'(m_hh) << (2 * HALF_W));

    always_comb begin
        y_d         = y_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            y_d         = sum_d;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_n2_mult4x4_approx.sv
// Bench for n2_mult4x4_approx: approximate and exact instances driven in lockstep.
module tb_n2_mult4x4_approx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    n2_mult4x4_approx_if bus1 ();
    n2_mult4x4_approx_if bus0 ();

    n2_mult4x4_approx #(.APPROX(1)) dut_apx (.clk(clk), .rst(rst), .bus(bus1.slave));
    n2_mult4x4_approx #(.APPROX(0)) dut_ext (.clk(clk), .rst(rst), .bus(bus0.slave));

    always #5 clk = ~clk;

    // Reference: product of halves by plain arithmetic, 3x3 replaced by 7 when approximate.
    function automatic int sub_mul(input int x, input int y, input bit apx);
        if (apx && x == 3 && y == 3) return 7;
        return x * y;
    endfunction

    function automatic int model(input int a, input int b, input bit apx);
        int ah, al, bh, bl;
        ah = a / 4; al = a % 4; bh = b / 4; bl = b % 4;
        return sub_mul(al, bl, apx) + 4 * sub_mul(ah, bl, apx)
             + 4 * sub_mul(al, bh, apx) + 16 * sub_mul(ah, bh, apx);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int a, input int b);
        @(negedge clk);
        bus1.in_valid = v; bus1.a = 4'(a); bus1.b = 4'(b);
        bus0.in_valid = v; bus0.a = 4'(a); bus0.b = 4'(b);
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string tag, input int a, input int b, input int exp_apx);
        drive(1'b1, a, b);
        chk({tag, "_y"}, int'(bus1.y), exp_apx);
        chk({tag, "_model"}, int'(bus1.y), model(a, b, 1'b1));
        chk({tag, "_ov"}, int'(bus1.out_valid), 1);
    endtask

    initial begin
        int exact_cnt, miss_cnt, bad_err;
        int exp1, exp0, ra, rb;
        bit rv;

        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0;
        #1;
        chk("rst_y", int'(bus1.y), 0);
        chk("rst_ov", int'(bus1.out_valid), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 0, 0);
        chk("idle_y", int'(bus1.y), 0);
        chk("idle_ov", int'(bus1.out_valid), 0);

        // Asynchronous reset while a result is being presented.
        drive(1'b1, 9, 9);
        chk("pre_rst_ov", int'(bus1.out_valid), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_y", int'(bus1.y), 0);
        chk("async_rst_ov", int'(bus1.out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        op("post_rst", 5, 6, 30);

        op("a3b3", 3, 3, 7);
        op("a12b12", 12, 12, 112);
        op("a15b15", 15, 15, 175);
        op("a10b13", 10, 13, 130);
        op("a15b0", 15, 0, 0);
        op("a7b9", 7, 9, 63);

        op("stream0", 3, 3, 7);
        op("stream1", 2, 2, 4);
        op("stream2", 15, 15, 175);
        drive(1'b0, 1, 1);
        chk("gap_ov", int'(bus1.out_valid), 0);
        chk("gap_y_hold", int'(bus1.y), 175);

        exact_cnt = 0; miss_cnt = 0; bad_err = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                drive(1'b1, ia, ib);
                chk("sweep_apx", int'(bus1.y), model(ia, ib, 1'b1));
                chk("sweep_ext", int'(bus0.y), ia * ib);
                if (int'(bus1.y) == ia * ib) exact_cnt++;
                else begin
                    miss_cnt++;
                    if (!(int'(bus1.y) < ia * ib) || (((ia * ib) - int'(bus1.y)) % 2) != 0)
                        bad_err++;
                end
            end
        end
        chk("sweep_exact_cnt", exact_cnt, 207);
        chk("sweep_miss_cnt", miss_cnt, 49);
        chk("sweep_err_sign_parity", bad_err, 0);

        // Random traffic with idle gaps; y must hold across non-valid cycles.
        exp1 = int'(bus1.y); exp0 = int'(bus0.y);
        for (int k = 0; k < 60; k++) begin
            rv = ($urandom_range(0, 3) != 0);
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            drive(rv, ra, rb);
            if (rv) begin
                exp1 = model(ra, rb, 1'b1);
                exp0 = ra * rb;
            end
            chk("rand_y_apx", int'(bus1.y), exp1);
            chk("rand_y_ext", int'(bus0.y), exp0);
            chk("rand_ov", int'(bus1.out_valid), int'(rv));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
